recipe_scheduler: RTL and testbench

- Upstream stage of the stepper-motor dispenser.
- Accepts colour/recipe requests through a valid/ready handshake and queues them in a small FIFO.
- Maps each request id to per-colour drop round counts (red, yellow, blue).
- Launches one dispense cycle at a time with a start pulse, then waits for the dispenser's done pulse or a watchdog timeout before issuing the next request.

---
 rtl/recipe_scheduler_if.sv | 25 ++
 rtl/recipe_scheduler.sv | 159 +++++++++++++++
 tb/tb_recipe_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/recipe_scheduler_if.sv
// Request and dispenser handshake bundle for the recipe scheduler.
// The master side is the requester together with the dispenser; the
// slave side is the scheduler itself.
interface recipe_scheduler_if #(
    parameter int TIME_W = 10
);
    logic              req_valid;
    logic [3:0]        req_id;
    logic              req_ready;
    logic              disp_start;
    logic              disp_done;
    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] y_time;
    logic [TIME_W-1:0] b_time;

    modport master (
        output req_valid, req_id, disp_done,
        input  req_ready, disp_start, r_time, y_time, b_time
    );

    modport slave (
        input  req_valid, req_id, disp_done,
        output req_ready, disp_start, r_time, y_time, b_time
    );
endinterface

// File: rtl/recipe_scheduler.sv
// Recipe scheduler: queues recipe ids in a small FIFO, maps each id to
// red/yellow/blue drop round counts at pop time and launches one dispense
// cycle at a time, guarded by a watchdog.
module recipe_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIME_W  = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    recipe_scheduler_if.slave        bus,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     err_id,
    output logic                     err_timeout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [WD_W-1:0]   wd_q;
    logic [TIME_W-1:0] r_q, y_q, b_q;
    logic [TIME_W-1:0] tbl_r, tbl_y, tbl_b;
    logic [2:0]        head_id;
    logic              full, empty, accept, push, pop, timeout_hit;

    // Ids 8..15 have bit 3 set and are rejected; only 3 bits are stored.
    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign accept      = bus.req_valid && bus.req_ready;
    assign push        = accept && !bus.req_id[3];
    assign head_id     = fifo_mem[rd_ptr];

    assign bus.req_ready  = !full;
    assign bus.disp_start = (state_q == ST_LOAD);
    assign bus.r_time     = r_q;
    assign bus.y_time     = y_q;
    assign bus.b_time     = b_q;
    assign busy           = (state_q != ST_IDLE);
    assign queue_count    = count_q;

    // Recipe table: drop round counts for the id at the head of the queue.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        tbl_r = '0;
        tbl_y = '0;
        tbl_b = '0;
        case (head_id)
            3'd0: begin tbl_r = TIME_W'(5);  tbl_y = TIME_W'(7);  tbl_b = TIME_W'(9);  end
            3'd1: begin tbl_r = TIME_W'(10);                                            end
            3'd2: begin                      tbl_y = TIME_W'(10);                       end
            3'd3: begin                                           tbl_b = TIME_W'(10); end
            3'd4: begin tbl_r = TIME_W'(5);  tbl_y = TIME_W'(5);                        end
            3'd5: begin                      tbl_y = TIME_W'(5);  tbl_b = TIME_W'(5);  end
            3'd6: begin tbl_r = TIME_W'(5);                       tbl_b = TIME_W'(5);  end
            default: begin tbl_r = TIME_W'(3); tbl_y = TIME_W'(3); tbl_b = TIME_W'(3); end
        endcase
    end

    // Next-state logic: pop on leaving IDLE, done beats the watchdog in WAIT.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_LOAD;
                    pop     = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.disp_done) begin
                    state_d = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    state_d     = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FIFO storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; emptiness comes from
        // count_q, so clearing storage would only cost reset fan-out.
        if (push) fifo_mem[wr_ptr] <= bus.req_id[2:0];
    end

    // FIFO pointers (wrap modulo DEPTH) and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Round counts latched at pop and held until the next job loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
            y_q <= '0;
            b_q <= '0;
        end else if (pop) begin
            r_q <= tbl_r;
            y_q <= tbl_y;
            b_q <= tbl_b;
        end
    end

    // Watchdog: cleared while loading, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    wd_q <= '0;
        else if (state_q == ST_LOAD) wd_q <= '0;
        else if (state_q == ST_WAIT) wd_q <= wd_q + WD_W'(1);
    end

    // One-cycle error pulses for rejected ids and watchdog aborts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_id      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_id      <= accept && bus.req_id[3];
            err_timeout <= timeout_hit;
        end
    end
endmodule

// File: tb/tb_recipe_scheduler.sv
// Directed bench for recipe_scheduler: a table of single-job vectors plus
// hand-written sequences for backpressure, watchdog and mid-job reset.
module tb_recipe_scheduler;
    localparam int DEPTH   = 4;
    localparam int TIME_W  = 10;
    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [2:0] queue_count;
    logic       err_id;
    logic       err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    recipe_scheduler_if #(.TIME_W(TIME_W)) bus ();

    recipe_scheduler #(
        .DEPTH  (DEPTH),
        .TIME_W (TIME_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .queue_count(queue_count),
        .err_id     (err_id),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] id;
        logic       ok;
        int         r;
        int         y;
        int         b;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_times(input string name, input int r, input int y, input int b);
        check({name, "_r"}, int'(bus.r_time), r);
        check({name, "_y"}, int'(bus.y_time), y);
        check({name, "_b"}, int'(bus.b_time), b);
    endtask

    // From WAIT: finish the current job, then expect the next one to load.
    task automatic next_job(input int r, input int y, input int b, input int cnt);
        bus.disp_done = 1'b1;
        step();
        bus.disp_done = 1'b0;
        check("nj_idle_busy", int'(busy), 0);
        step();
        check("nj_start", int'(bus.disp_start), 1);
        check("nj_count", int'(queue_count), cnt);
        check_times("nj", r, y, b);
        step();
        check("nj_wait_busy", int'(busy), 1);
        check("nj_start_off", int'(bus.disp_start), 0);
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{4'd0,  1'b1, 5,  7,  9};
        vecs[1] = '{4'd1,  1'b1, 10, 0,  0};
        vecs[2] = '{4'd2,  1'b1, 0,  10, 0};
        vecs[3] = '{4'd3,  1'b1, 0,  0,  10};
        vecs[4] = '{4'd9,  1'b0, 0,  0,  0};
        vecs[5] = '{4'd4,  1'b1, 5,  5,  0};
        vecs[6] = '{4'd5,  1'b1, 0,  5,  5};
        vecs[7] = '{4'd6,  1'b1, 5,  0,  5};
        vecs[8] = '{4'd15, 1'b0, 0,  0,  0};
        vecs[9] = '{4'd7,  1'b1, 3,  3,  3};

        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_id    = '0;
        bus.disp_done = 1'b0;

        // Reset state.
        #1;
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_start", int'(bus.disp_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(queue_count), 0);
        check("rst_err_id", int'(err_id), 0);
        check("rst_err_to", int'(err_timeout), 0);
        check_times("rst", 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();
        check("rel_ready", int'(bus.req_ready), 1);

        // Table vectors: one job (or one rejected id) at a time.
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1;
            bus.req_id    = vecs[i].id;
            step();
            bus.req_valid = 1'b0;
            if (!vecs[i].ok) begin
                check("bad_err_id", int'(err_id), 1);
                check("bad_count", int'(queue_count), 0);
                check("bad_busy", int'(busy), 0);
                step();
                check("bad_err_clr", int'(err_id), 0);
                check("bad_no_start", int'(bus.disp_start), 0);
            end else begin
                check("v_count", int'(queue_count), 1);
                check("v_err_id", int'(err_id), 0);
                step();
                check("v_start", int'(bus.disp_start), 1);
                check("v_busy", int'(busy), 1);
                check("v_count_pop", int'(queue_count), 0);
                check_times("v", vecs[i].r, vecs[i].y, vecs[i].b);
                step();
                check("v_start_once", int'(bus.disp_start), 0);
                check("v_wait_busy", int'(busy), 1);
                bus.disp_done = 1'b1;
                step();
                bus.disp_done = 1'b0;
                check("v_done_idle", int'(busy), 0);
                check_times("v_hold", vecs[i].r, vecs[i].y, vecs[i].b);
            end
        end

        // Backpressure: ids 1..5 back to back, id1 loads, four stay queued.
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd1;
        step();
        bus.req_id = 4'd2;
        step();
        check("bp_start", int'(bus.disp_start), 1);
        check_times("bp_first", 10, 0, 0);
        bus.req_id = 4'd3;
        step();
        bus.req_id = 4'd4;
        step();
        bus.req_id = 4'd5;
        step();
        check("bp_full_count", int'(queue_count), 4);
        check("bp_not_ready", int'(bus.req_ready), 0);
        bus.req_id = 4'd6;
        repeat (3) step();
        check("bp_stall_count", int'(queue_count), 4);
        check("bp_stall_ready", int'(bus.req_ready), 0);
        bus.req_valid = 1'b0;
        next_job(0, 10, 0, 3);
        next_job(0, 0, 10, 2);
        next_job(5, 5, 0, 1);
        next_job(0, 5, 5, 0);
        bus.disp_done = 1'b1;
        step();
        bus.disp_done = 1'b0;
        check("bp_end_busy", int'(busy), 0);
        check("bp_end_count", int'(queue_count), 0);

        // disp_done while IDLE with an empty queue is ignored.
        bus.disp_done = 1'b1;
        step();
        bus.disp_done = 1'b0;
        check("idle_done_busy", int'(busy), 0);
        check("idle_done_start", int'(bus.disp_start), 0);

        // Watchdog: id0 never completes, id7 is queued behind it.
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd0;
        step();
        bus.req_id = 4'd7;
        step();
        bus.req_valid = 1'b0;
        check("to_start", int'(bus.disp_start), 1);
        bus.disp_done = 1'b1;
        step();
        bus.disp_done = 1'b0;
        check("load_done_ignored", int'(busy), 1);
        check("to_count", int'(queue_count), 1);
        repeat (TIMEOUT - 1) step();
        check("to_not_yet", int'(err_timeout), 0);
        check("to_still_busy", int'(busy), 1);
        step();
        check("to_pulse", int'(err_timeout), 1);
        check("to_idle", int'(busy), 0);
        check("to_count_after", int'(queue_count), 1);
        check_times("to_hold", 5, 7, 9);
        step();
        check("to_pulse_clr", int'(err_timeout), 0);
        check("to_next_start", int'(bus.disp_start), 1);
        check_times("to_next", 3, 3, 3);
        step();
        // done coinciding with the watchdog's last cycle wins.
        repeat (TIMEOUT - 1) step();
        check("tie_busy", int'(busy), 1);
        bus.disp_done = 1'b1;
        step();
        bus.disp_done = 1'b0;
        check("tie_idle", int'(busy), 0);
        check("tie_no_err", int'(err_timeout), 0);
        step();
        check("tie_no_err2", int'(err_timeout), 0);

        // Asynchronous reset mid-WAIT with two entries queued.
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd0;
        step();
        bus.req_id = 4'd1;
        step();
        bus.req_id = 4'd2;
        step();
        bus.req_valid = 1'b0;
        check("mr_count", int'(queue_count), 2);
        check("mr_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("mr_busy_clr", int'(busy), 0);
        check("mr_start_clr", int'(bus.disp_start), 0);
        check("mr_count_clr", int'(queue_count), 0);
        check("mr_ready", int'(bus.req_ready), 1);
        check_times("mr", 0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mr_quiet_start", int'(bus.disp_start), 0);
        end
        check("mr_quiet_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
